ddsm_cfg_ctrl: RTL and testbench
================================

Name: ddsm_cfg_ctrl

Overview:
Configuration and sequencing controller for the SP-MASH delta-sigma modulator chain.
- Accepts a new fractional word and modulator order through a valid/ready handshake.
- Drives the chain's input word, per-stage enables and synchronous clear.
- Runs a flush/settle sequence before flagging the output as settled, so a divider consuming the DDSM carry stream never sees a half-updated chain.

Parameters:
WIDTH, 9, fractional word width; equals the EFM stage width.
ORDER_MAX, 3, number of cascaded EFM stages in the chain (1..7).
FLUSH_CYC, 2, cycles clr_o is held high during a flushing reconfiguration (>=1).
SETTLE_CYC, 16, cycles the chain runs after (re)configuration before settled_o asserts (>=1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  global run enable; low forces IDLE.
cfg_valid  in  1  configuration offer.
cfg_ready  out  1  controller can accept a configuration.
cfg_frac  in  WIDTH  fractional word for the chain input.
cfg_order  in  3  requested modulator order (1..ORDER_MAX).
cfg_flush  in  1  1 = clear chain accumulators when applying.
x_o  out  WIDTH  registered fractional word to EFM stage 1.
order_o  out  3  registered active order.
stage_en_o  out  ORDER_MAX  per-stage enable, thermometer coded.
clr_o  out  1  synchronous clear to all EFM accumulators.
settled_o  out  1  chain output is valid for the current configuration.
busy_o  out  1  reconfiguration in progress (LOAD/FLUSH/SETTLE).
err_o  out  1  one-cycle pulse: rejected configuration.
apply_cnt_o  out  8  count of applied configurations; wraps 255->0.

Behaviour:
- Reset (async): state IDLE; x_o=0, order_o=0, stage_en_o=0, clr_o=0, settled_o=0, busy_o=0, err_o=0, apply_cnt_o=0; shadow registers=0.
- cfg_ready = en & (state==IDLE | state==RUN). It is combinational from en and registered state. Handshake completes on an edge where cfg_valid & cfg_ready.
- Validation at acceptance:
  - cfg_order==0 or cfg_order>ORDER_MAX: configuration is consumed.
  - err_o=1 for the next cycle; no state or output change.
- Valid acceptance: shadow <= {cfg_frac, cfg_order, cfg_flush}; state -> LOAD.
- FSM states: IDLE, LOAD, FLUSH, SETTLE, RUN.
  - LOAD, 1 cycle: x_o <= shadow frac; order_o <= shadow order; apply_cnt_o += 1; next state FLUSH if the flush bit is set, else SETTLE. stage_en_o is 0 in LOAD only when flushing; otherwise it keeps its previous value.
  - FLUSH, FLUSH_CYC cycles: clr_o=1; stage_en_o=0. Then SETTLE.
  - SETTLE, SETTLE_CYC cycles: stage_en_o[i]=1 for i<order_o; a counter counts down. Then RUN.
  - RUN: settled_o=1; stage_en_o held; remains until a new configuration or en low.
- Registered outputs follow the state:
  - busy_o=1 in LOAD/FLUSH/SETTLE.
  - settled_o=1 only in RUN.
  - clr_o=1 only in FLUSH.
- Latency from accept edge E0 to settled_o high:
  - flush: E0+2+FLUSH_CYC+SETTLE_CYC-1 edges, i.e. E0+19 with defaults.
  - no flush: E0+SETTLE_CYC+1, i.e. E0+17.
- Reconfiguration from RUN: settled_o drops the cycle after acceptance; the old x_o is held until LOAD updates it.
- en low in any state: the next edge goes to IDLE; stage_en_o=0, clr_o=0, settled_o=0, busy_o=0; x_o and order_o retain their values; counters clear.
- en low coincident with cfg_valid: not accepted, because cfg_ready is low.
- cfg_valid during busy: not accepted; the requester must hold cfg_valid/data stable until the handshake completes.
- cfg_frac=0 is legal (integer divide); the full sequence still runs.
- Counter width: $clog2(max(FLUSH_CYC,SETTLE_CYC)+1); a single shared down-counter is allowed.

Decomposition:
- Package ddsm_pkg:
  - state enum encoding (IDLE=0, LOAD=1, FLUSH=2, SETTLE=3, RUN=4);
  - ORDER_W=3 constant;
  - function order_to_therm(order, ORDER_MAX).
- No sub-module needed. Optionally factor the down-counter as ddsm_cycle_timer (load value, start, done pulse).

Test Plan:
- Reset release, en=1, offer frac=0x0A5, order=3, flush=1 -> cfg_ready=1; clr_o high for exactly 2 cycles; stage_en_o=3'b111; settled_o rises 19 edges after accept; x_o=0x0A5; apply_cnt_o=1.
- From RUN, offer frac=0x1FF, order=2, flush=0 -> settled_o drops next cycle; clr_o never high; stage_en_o=3'b011; settled_o back 17 edges after accept.
- Offer order=0, then order=4 -> each gives a one-cycle err_o pulse; x_o, order_o, settled_o and apply_cnt_o unchanged.
- Drop en during SETTLE with cfg_valid high -> next edge: IDLE, stage_en_o=0, busy_o=0; no handshake while en=0. Re-raise en -> cfg_ready=1 and the pending config is accepted.
- Hold cfg_valid through a busy sequence with a second config -> accepted only on the first RUN cycle; exactly one LOAD per handshake.
- Apply 256 valid configs -> apply_cnt_o wraps to 0. Assert rst_n low mid-FLUSH -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/ddsm_cfg_ctrl_pkg.sv
// Shared types and helpers for the SP-MASH DDSM configuration controller.
package ddsm_pkg;

  localparam int unsigned ORDER_W = 3;
  localparam int unsigned THERM_W = (1 << ORDER_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  // Thermometer code: bit i set when stage i+1 is part of the active chain.
  function automatic logic [THERM_W-1:0] order_to_therm(
    input logic [ORDER_W-1:0] order,
    input int unsigned        order_max
  );
    logic [THERM_W-1:0] therm;
    therm = '0;
    for (int unsigned i = 0; i < THERM_W; i++) begin
      therm[i] = (i < 32'(order)) && (i < order_max);
    end
    return therm;
  endfunction

  function automatic logic order_is_legal(
    input logic [ORDER_W-1:0] order,
    input int unsigned        order_max
  );
    return (order != '0) && (32'(order) <= order_max);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddsm_cfg_ctrl_if.sv
// Configuration offer channel (valid/ready) into the DDSM controller.
interface ddsm_cfg_ctrl_if
  import ddsm_pkg::*;
#(
  parameter int unsigned WIDTH = 9
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [WIDTH-1:0]   cfg_frac;
  logic [ORDER_W-1:0] cfg_order;
  logic               cfg_flush;

  modport master (
    output cfg_valid,
    output cfg_frac,
    output cfg_order,
    output cfg_flush,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_frac,
    input  cfg_order,
    input  cfg_flush,
    output cfg_ready
  );

endinterface

// File: rtl/ddsm_cfg_ctrl_timer.sv
// Shared down-counter timing the FLUSH and SETTLE phases.
module ddsm_cycle_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // start wins over expiry so back-to-back phases chain without a gap
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start_i) begin
      cnt_d = load_val_i;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/ddsm_cfg_ctrl.sv
// DDSM chain configuration/sequencing controller: accept, load, flush, settle, run.
module ddsm_cfg_ctrl
  import ddsm_pkg::*;
#(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned ORDER_MAX  = 3,
  parameter int unsigned FLUSH_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  ddsm_cfg_ctrl_if.slave       cfg,
  output logic [WIDTH-1:0]     x_o,
  output logic [ORDER_W-1:0]   order_o,
  output logic [ORDER_MAX-1:0] stage_en_o,
  output logic                 clr_o,
  output logic                 settled_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [7:0]           apply_cnt_o
);

  localparam int unsigned CNT_W = $clog2(max2(FLUSH_CYC, SETTLE_CYC) + 1);

  state_e state_q, state_d;

  logic               accept;
  logic               cfg_ok;

  logic [WIDTH-1:0]   sh_frac_q,  sh_frac_d;
  logic [ORDER_W-1:0] sh_order_q, sh_order_d;
  logic               sh_flush_q, sh_flush_d;

  logic [WIDTH-1:0]     x_q,        x_d;
  logic [ORDER_W-1:0]   order_q,    order_d;
  logic [ORDER_MAX-1:0] stage_en_q, stage_en_d;
  logic                 clr_q,      clr_d;
  logic                 settled_q,  settled_d;
  logic                 busy_q,     busy_d;
  logic                 err_q,      err_d;
  logic [7:0]           apply_q,    apply_d;

  logic [ORDER_MAX-1:0] stage_therm;

  logic             tmr_clear;
  logic             tmr_start;
  logic [CNT_W-1:0] tmr_load;
  logic             tmr_done;

  assign cfg.cfg_ready = en && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok        = order_is_legal(cfg.cfg_order, ORDER_MAX);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: if (accept && cfg_ok) state_d = ST_LOAD;
        ST_LOAD:         state_d = sh_flush_q ? ST_FLUSH : ST_SETTLE;
        ST_FLUSH:        if (tmr_done) state_d = ST_SETTLE;
        ST_SETTLE:       if (tmr_done) state_d = ST_RUN;
        default:         state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- phase timer ----------------
  assign tmr_clear = !en;
  assign tmr_start = (state_d != state_q) &&
                     ((state_d == ST_FLUSH) || (state_d == ST_SETTLE));
  assign tmr_load  = (state_d == ST_FLUSH) ? CNT_W'(FLUSH_CYC - 1)
                                           : CNT_W'(SETTLE_CYC - 1);

  ddsm_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .start_i    (tmr_start),
    .load_val_i (tmr_load),
    .done_o     (tmr_done)
  );

  // ---------------- output / datapath next values ----------------
  // Flags are registered from state_d so they line up with the state they describe.
  always_comb begin
    sh_frac_d  = sh_frac_q;
    sh_order_d = sh_order_q;
    sh_flush_d = sh_flush_q;
    x_d        = x_q;
    order_d    = order_q;
    apply_d    = apply_q;

    if (accept && cfg_ok) begin
      sh_frac_d  = cfg.cfg_frac;
      sh_order_d = cfg.cfg_order;
      sh_flush_d = cfg.cfg_flush;
    end

    if (en && (state_q == ST_LOAD)) begin
      x_d     = sh_frac_q;
      order_d = sh_order_q;
      apply_d = apply_q + 8'd1;
    end

    stage_therm = ORDER_MAX'(order_to_therm(order_d, ORDER_MAX));

    unique case (state_d)
      ST_LOAD:   stage_en_d = sh_flush_d ? '0 : stage_en_q;
      ST_FLUSH:  stage_en_d = '0;
      ST_SETTLE: stage_en_d = stage_therm;
      ST_RUN:    stage_en_d = stage_en_q;
      default:   stage_en_d = '0;
    endcase

    clr_d     = (state_d == ST_FLUSH);
    settled_d = (state_d == ST_RUN);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_FLUSH) || (state_d == ST_SETTLE);
    err_d     = accept && !cfg_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_frac_q  <= '0;
      sh_order_q <= '0;
      sh_flush_q <= 1'b0;
      x_q        <= '0;
      order_q    <= '0;
      stage_en_q <= '0;
      clr_q      <= 1'b0;
      settled_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      apply_q    <= '0;
    end else begin
      sh_frac_q  <= sh_frac_d;
      sh_order_q <= sh_order_d;
      sh_flush_q <= sh_flush_d;
      x_q        <= x_d;
      order_q    <= order_d;
      stage_en_q <= stage_en_d;
      clr_q      <= clr_d;
      settled_q  <= settled_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      apply_q    <= apply_d;
    end
  end

  assign x_o         = x_q;
  assign order_o     = order_q;
  assign stage_en_o  = stage_en_q;
  assign clr_o       = clr_q;
  assign settled_o   = settled_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign apply_cnt_o = apply_q;

endmodule

// File: tb/tb_ddsm_cfg_ctrl.sv
// Directed self-checking bench for ddsm_cfg_ctrl with default parameters.
module tb_ddsm_cfg_ctrl;
  import ddsm_pkg::*;

  localparam int unsigned WIDTH      = 9;
  localparam int unsigned ORDER_MAX  = 3;
  localparam int unsigned FLUSH_CYC  = 2;
  localparam int unsigned SETTLE_CYC = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [WIDTH-1:0]     x_o;
  logic [ORDER_W-1:0]   order_o;
  logic [ORDER_MAX-1:0] stage_en_o;
  logic                 clr_o;
  logic                 settled_o;
  logic                 busy_o;
  logic                 err_o;
  logic [7:0]           apply_cnt_o;

  ddsm_cfg_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

  ddsm_cfg_ctrl #(
    .WIDTH      (WIDTH),
    .ORDER_MAX  (ORDER_MAX),
    .FLUSH_CYC  (FLUSH_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg         (cfg_if),
    .x_o         (x_o),
    .order_o     (order_o),
    .stage_en_o  (stage_en_o),
    .clr_o       (clr_o),
    .settled_o   (settled_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .apply_cnt_o (apply_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [8:0] frac, input logic [2:0] order, input logic flush);
    cfg_if.cfg_frac  = frac;
    cfg_if.cfg_order = order;
    cfg_if.cfg_flush = flush;
    cfg_if.cfg_valid = 1'b1;
  endtask

  // Ticks until settled_o is seen (bounded); returns clr_o-high count and settle edge index.
  task automatic watch(input int budget, output int clr_n, output int settle_n);
    clr_n    = 0;
    settle_n = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (clr_o) clr_n++;
      if (settled_o) begin
        settle_n = n;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int clr_n, settle_n, hs, hs_cnt;

    rst_n            = 1'b0;
    en               = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_frac  = '0;
    cfg_if.cfg_order = '0;
    cfg_if.cfg_flush = 1'b0;
    #12;
    check("rst_x",       32'(x_o),         0);
    check("rst_order",   32'(order_o),     0);
    check("rst_stage",   32'(stage_en_o),  0);
    check("rst_clr",     32'(clr_o),       0);
    check("rst_settled", 32'(settled_o),   0);
    check("rst_busy",    32'(busy_o),      0);
    check("rst_err",     32'(err_o),       0);
    check("rst_apply",   32'(apply_cnt_o), 0);
    check("rst_ready_en0", 32'(cfg_if.cfg_ready), 0);
    rst_n = 1'b1;
    tick();

    // 1: flushing configuration from IDLE
    en = 1'b1;
    offer(9'h0A5, 3'd3, 1'b1);
    #1;
    check("t1_ready", 32'(cfg_if.cfg_ready), 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("t1_busy_load", 32'(busy_o), 1);
    tick();
    check("t1_x_loaded",   32'(x_o),         'h0A5);
    check("t1_apply1",     32'(apply_cnt_o), 1);
    check("t1_clr_first",  32'(clr_o),       1);
    check("t1_stage_zero", 32'(stage_en_o),  0);
    watch(40, clr_n, settle_n);
    check("t1_clr_cycles", 32'(clr_n + 1),    2);
    check("t1_settle_lat", 32'(settle_n + 1), 19);
    check("t1_stage",      32'(stage_en_o),   'b111);
    check("t1_order",      32'(order_o),      3);
    check("t1_busy_run",   32'(busy_o),       0);

    // 2: non-flushing reconfiguration from RUN
    offer(9'h1FF, 3'd2, 1'b0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("t2_settle_drop", 32'(settled_o),  0);
    check("t2_x_held",      32'(x_o),        'h0A5);
    check("t2_stage_held",  32'(stage_en_o), 'b111);
    watch(40, clr_n, settle_n);
    check("t2_no_clr",      32'(clr_n),       0);
    check("t2_settle_lat",  32'(settle_n),    17);
    check("t2_stage",       32'(stage_en_o),  'b011);
    check("t2_x",           32'(x_o),         'h1FF);
    check("t2_apply2",      32'(apply_cnt_o), 2);

    // 3: illegal orders
    offer(9'h055, 3'd0, 1'b1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("t3_err_o0",     32'(err_o),       1);
    check("t3_settled_o0", 32'(settled_o),   1);
    check("t3_x_o0",       32'(x_o),         'h1FF);
    check("t3_busy_o0",    32'(busy_o),      0);
    tick();
    check("t3_err_clear0", 32'(err_o),       0);
    offer(9'h066, 3'd4, 1'b0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("t3_err_o4",     32'(err_o),       1);
    check("t3_order_o4",   32'(order_o),     2);
    check("t3_apply_o4",   32'(apply_cnt_o), 2);
    tick();
    check("t3_err_clear4", 32'(err_o),       0);
    check("t3_settled_o4", 32'(settled_o),   1);

    // 4: en dropped during SETTLE with an offer pending
    offer(9'h033, 3'd1, 1'b1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    repeat (5) tick();
    check("t4_busy_settle",  32'(busy_o),     1);
    check("t4_stage_settle", 32'(stage_en_o), 'b001);
    offer(9'h044, 3'd2, 1'b0);
    en = 1'b0;
    #1;
    check("t4_ready_en0", 32'(cfg_if.cfg_ready), 0);
    tick();
    check("t4_stage_idle", 32'(stage_en_o),  0);
    check("t4_busy_idle",  32'(busy_o),      0);
    check("t4_clr_idle",   32'(clr_o),       0);
    check("t4_settled",    32'(settled_o),   0);
    check("t4_x_kept",     32'(x_o),         'h033);
    check("t4_order_kept", 32'(order_o),     1);
    repeat (3) tick();
    check("t4_no_hs", 32'(apply_cnt_o), 3);
    check("t4_idle_busy", 32'(busy_o), 0);
    en = 1'b1;
    #1;
    check("t4_ready_en1", 32'(cfg_if.cfg_ready), 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("t4_busy_acc", 32'(busy_o), 1);
    watch(40, clr_n, settle_n);
    check("t4_settle_lat", 32'(settle_n),    17);
    check("t4_x",          32'(x_o),         'h044);
    check("t4_stage",      32'(stage_en_o),  'b011);
    check("t4_apply4",     32'(apply_cnt_o), 4);

    // 5: second config held valid through a busy sequence
    offer(9'h011, 3'd1, 1'b0);
    tick();
    offer(9'h022, 3'd3, 1'b0);
    hs = -1;
    for (int n = 1; n <= 40; n++) begin
      if (cfg_if.cfg_valid && cfg_if.cfg_ready) begin
        hs = n;
        check("t5_first_run", 32'(settled_o), 1);
        check("t5_x_a",       32'(x_o),       'h011);
      end
      tick();
      if (hs >= 0) begin
        cfg_if.cfg_valid = 1'b0;
        break;
      end
    end
    check("t5_hs_edge", 32'(hs), 18);
    watch(40, clr_n, settle_n);
    check("t5_settle_lat", 32'(settle_n),    17);
    check("t5_apply6",     32'(apply_cnt_o), 6);
    check("t5_x_b",        32'(x_o),         'h022);
    check("t5_stage",      32'(stage_en_o),  'b111);

    // 6: apply counter wrap, frac=0 configs
    offer(9'h000, 3'd1, 1'b0);
    hs_cnt = 0;
    for (int c = 0; c < 6000; c++) begin
      if (cfg_if.cfg_valid && cfg_if.cfg_ready) hs_cnt++;
      tick();
      if (hs_cnt == 250) begin
        cfg_if.cfg_valid = 1'b0;
        break;
      end
    end
    check("t6_hs_count", 32'(hs_cnt), 250);
    tick();
    check("t6_apply_wrap", 32'(apply_cnt_o), 0);
    check("t6_x_zero",     32'(x_o),         0);
    watch(40, clr_n, settle_n);
    check("t6_frac0_settle", 32'(settle_n),   16);
    check("t6_stage",        32'(stage_en_o), 'b001);

    // 7: asynchronous reset in the middle of FLUSH
    offer(9'h0AA, 3'd3, 1'b1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();
    check("t7_clr_flush",  32'(clr_o),  1);
    check("t7_busy_flush", 32'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_x",       32'(x_o),         0);
    check("t7_rst_order",   32'(order_o),     0);
    check("t7_rst_stage",   32'(stage_en_o),  0);
    check("t7_rst_clr",     32'(clr_o),       0);
    check("t7_rst_settled", 32'(settled_o),   0);
    check("t7_rst_busy",    32'(busy_o),      0);
    check("t7_rst_err",     32'(err_o),       0);
    check("t7_rst_apply",   32'(apply_cnt_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
